// File: rtl/u_mac_acc8_pkg.sv
// u_mac_acc8_pkg: shared constants and types for the product accumulator.
// Ports: none (package). Provides default widths, product width and the
// group-tracking state enum.
package u_mac_acc8_pkg;

  // Default accumulator/result width and per-group term counter width.
  localparam int ACC_W_DEF = 16;
  localparam int CNT_W_DEF = 8;

  // Product width produced by the upstream 4x4 unsigned multiplier.
  localparam int PROD_W = 8;

  // IDLE: no terms in the current group; ACCUM: at least one term summed.
  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/u_mac_acc8.sv
// u_mac_acc8: registers 8-bit unsigned products and accumulates them per group
// (group closed by prod_last), emitting sum / term count / sticky wrap flag.
// Ports: clk, rst (async active-high); prod/prod_valid/prod_last/prod_ready in;
// clr (sync abort); acc_out/acc_cnt/acc_ovf/acc_valid/acc_ready out.
module u_mac_acc8
  import u_mac_acc8_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  input  logic              prod_last,
  output logic              prod_ready,
  input  logic              clr,
  output logic [ACC_W-1:0]  acc_out,
  output logic [CNT_W-1:0]  acc_cnt,
  output logic              acc_ovf,
  output logic              acc_valid,
  input  logic              acc_ready
);

  state_t              state, state_next;
  logic                s1_valid;
  logic [PROD_W-1:0]   s1_prod;
  logic                s1_last;
  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt;
  logic                ovf;

  logic                advance;
  logic                accept;
  logic                load;
  logic [ACC_W:0]      sum;
  logic [CNT_W-1:0]    cnt_next;
  logic                ovf_next;

  // Only a closing term has to wait for the output register; non-last terms
  // fold into acc regardless of downstream backpressure.
  assign advance    = s1_valid & ~(s1_last & acc_valid & ~acc_ready);
  assign prod_ready = ~rst & ~clr & (~s1_valid | advance);
  assign accept     = prod_valid & prod_ready;
  // clr wins over a closing term in s1: the group is aborted, nothing loads.
  assign load       = advance & s1_last & ~clr;

  // One extra bit so the carry out of the ACC_W-bit sum marks a wrap.
  assign sum      = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, s1_prod};
  assign ovf_next = ovf | sum[ACC_W];
  assign cnt_next = (&cnt) ? cnt : cnt + 1'b1;

  // Group tracking FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Group tracking FSM: next state.
  always_comb begin
    state_next = state;
    if (clr) begin
      state_next = IDLE;
    end else if (advance) begin
      state_next = s1_last ? IDLE : ACCUM;
    end
  end

  // Stage 1: input register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_last  <= 1'b0;
    end else if (clr) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_prod  <= prod;
      s1_last  <= prod_last;
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: running sum, cleared on abort or at group end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr || (advance && s1_last)) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (advance) begin
      acc <= sum[ACC_W-1:0];
      cnt <= cnt_next;
      ovf <= ovf_next;
    end
  end

  // Output holding register; a new result may replace a consumed one on the
  // same edge, keeping acc_valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_out   <= '0;
      acc_cnt   <= '0;
      acc_ovf   <= 1'b0;
      acc_valid <= 1'b0;
    end else if (load) begin
      acc_out   <= sum[ACC_W-1:0];
      acc_cnt   <= cnt_next;
      acc_ovf   <= ovf_next;
      acc_valid <= 1'b1;
    end else if (acc_ready) begin
      acc_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_u_mac_acc8.sv
// tb_u_mac_acc8: self-checking bench for u_mac_acc8 (table of groups plus
// hand-written stall / clr / reset / same-edge sequences, scoreboard queue).
module tb_u_mac_acc8;
  import u_mac_acc8_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  prod;
  logic        prod_valid;
  logic        prod_last;
  logic        prod_ready;
  logic        clr;
  logic [15:0] acc_out;
  logic [7:0]  acc_cnt;
  logic        acc_ovf;
  logic        acc_valid;
  logic        acc_ready;

  u_mac_acc8 #(.ACC_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .prod(prod), .prod_valid(prod_valid),
    .prod_last(prod_last), .prod_ready(prod_ready), .clr(clr),
    .acc_out(acc_out), .acc_cnt(acc_cnt), .acc_ovf(acc_ovf),
    .acc_valid(acc_valid), .acc_ready(acc_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] acc;
    logic [7:0]  cnt;
    logic        ovf;
  } res_t;

  typedef struct {
    int         n;
    logic [7:0] v[4];
    res_t       exp;
  } vec_t;

  res_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   vld_cycles = 0;
  int   stall_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Scoreboard: every consumed result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (acc_valid) vld_cycles++;
      if (prod_valid && !prod_ready && !clr) stall_seen++;
      if (acc_valid && acc_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(acc_out), 32'hFFFF_FFFF);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          chk("acc_out", 32'(acc_out), 32'(e.acc));
          chk("acc_cnt", 32'(acc_cnt), 32'(e.cnt));
          chk("acc_ovf", 32'(acc_ovf), 32'(e.ovf));
        end
      end
    end
  end

  task automatic send(input logic [7:0] v, input logic l);
    int t;
    prod = v; prod_last = l; prod_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!prod_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("send_timeout", 32'(t), 32'd0);
    @(posedge clk); #1;
    prod_valid = 1'b0; prod_last = 1'b0;
  endtask

  task automatic push(input logic [15:0] a, input logic [7:0] c, input logic o);
    res_t r;
    r.acc = a; r.cnt = c; r.ovf = o;
    exp_q.push_back(r);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  vec_t vt[4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    vt[0].n = 3; vt[0].v = '{8'd6, 8'd225, 8'd12, 8'd0};    vt[0].exp = '{16'd243, 8'd3, 1'b0};
    vt[1].n = 1; vt[1].v = '{8'd0, 8'd0, 8'd0, 8'd0};       vt[1].exp = '{16'd0, 8'd1, 1'b0};
    vt[2].n = 4; vt[2].v = '{8'd255, 8'd255, 8'd255, 8'd255}; vt[2].exp = '{16'd1020, 8'd4, 1'b0};
    vt[3].n = 2; vt[3].v = '{8'd1, 8'd2, 8'd0, 8'd0};       vt[3].exp = '{16'd3, 8'd2, 1'b0};

    rst = 1'b1; prod = '0; prod_valid = 1'b0; prod_last = 1'b0;
    clr = 1'b0; acc_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_prod_ready", 32'(prod_ready), 32'd0);
    chk("rst_acc_valid", 32'(acc_valid), 32'd0);
    chk("rst_acc_out", 32'(acc_out), 32'd0);
    chk("rst_acc_cnt", 32'(acc_cnt), 32'd0);
    chk("rst_acc_ovf", 32'(acc_ovf), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven groups with acc_ready=1: no stalls, one valid cycle each.
    stall_seen = 0;
    for (int i = 0; i < 4; i++) begin
      vld_cycles = 0;
      push(vt[i].exp.acc, vt[i].exp.cnt, vt[i].exp.ovf);
      for (int j = 0; j < vt[i].n; j++) send(vt[i].v[j], j == vt[i].n - 1);
      drain();
      repeat (2) @(posedge clk); #1;
      chk("valid_one_cycle", 32'(vld_cycles), 32'd1);
    end
    chk("no_input_stall", 32'(stall_seen), 32'd0);

    // Reset mid-group discards the partial sum.
    send(8'd100, 1'b0);
    send(8'd50, 1'b0);
    rst = 1'b1; #1;
    chk("rst_mid_prod_ready", 32'(prod_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    push(16'd7, 8'd1, 1'b0);
    send(8'd7, 1'b1);
    drain();

    // Wrap and counter saturation: 292*225 = 65700 = 65536 + 164.
    push(16'd164, 8'd255, 1'b1);
    for (int i = 0; i < 292; i++) send(8'd225, i == 291);
    push(16'd1, 8'd1, 1'b0);
    send(8'd1, 1'b1);
    drain();

    // Backpressure: result held, non-last term still folds in, last term stalls.
    acc_ready = 1'b0;
    push(16'd10, 8'd1, 1'b0);
    push(16'd50, 8'd2, 1'b0);
    send(8'd10, 1'b1);
    send(8'd20, 1'b0);
    send(8'd30, 1'b1);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (!(acc_valid && acc_out == 16'd10 && acc_cnt == 8'd1 && !prod_ready)) bad++;
      end
      chk("stall_hold_cycles_bad", 32'(bad), 32'd0);
    end
    @(posedge clk); #1;
    acc_ready = 1'b1;
    drain();

    // clr mid-group with a held result surviving the abort.
    acc_ready = 1'b0;
    push(16'd9, 8'd1, 1'b0);
    send(8'd9, 1'b1);
    send(8'd40, 1'b0);
    send(8'd60, 1'b0);
    clr = 1'b1; prod = 8'd77; prod_valid = 1'b1; prod_last = 1'b1;
    @(negedge clk);
    chk("clr_prod_ready", 32'(prod_ready), 32'd0);
    @(posedge clk); #1;
    clr = 1'b0; prod_valid = 1'b0; prod_last = 1'b0;
    @(negedge clk);
    chk("clr_held_valid", 32'(acc_valid), 32'd1);
    chk("clr_held_out", 32'(acc_out), 32'd9);
    chk("clr_held_cnt", 32'(acc_cnt), 32'd1);
    @(posedge clk); #1;
    acc_ready = 1'b1;
    push(16'd5, 8'd1, 1'b0);
    send(8'd5, 1'b1);
    drain();

    // Same-edge replace: consumed result and new result on one edge.
    push(16'd0, 8'd1, 1'b0);
    push(16'd3, 8'd1, 1'b0);
    send(8'd0, 1'b1);
    send(8'd3, 1'b1);
    @(negedge clk);
    chk("replace_first_valid", 32'(acc_valid), 32'd1);
    chk("replace_first_out", 32'(acc_out), 32'd0);
    @(negedge clk);
    chk("replace_second_valid", 32'(acc_valid), 32'd1);
    chk("replace_second_out", 32'(acc_out), 32'd3);
    drain();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/u_mac_acc8.md
Name: u_mac_acc8

Overview:
- Downstream consumer of the flat 4x4 unsigned carry-save/CLA multiplier.
- Registers each 8-bit unsigned product and accumulates it into an ACC_W-bit running sum.
- Emits one result per group of products; the group is terminated by `prod_last`.
- Valid/ready handshakes on both sides. One output holding register decouples the next pipeline stage.

Parameters:
- ACC_W, 16: accumulator and result width; must be ≥ 8.
- CNT_W, 8: width of the per-group term counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- prod  in  8  unsigned product from the multiplier.
- prod_valid  in  1  `prod` and `prod_last` are valid.
- prod_last  in  1  this product closes the current group.
- prod_ready  out  1  block accepts `prod` this cycle.
- clr  in  1  synchronous abort of the current group.
- acc_out  out  ACC_W  completed group sum, modulo 2^ACC_W.
- acc_cnt  out  CNT_W  number of terms in the group, saturating.
- acc_ovf  out  1  sticky flag: the sum wrapped at least once in this group.
- acc_valid  out  1  `acc_out`, `acc_cnt` and `acc_ovf` are valid.
- acc_ready  in  1  downstream consumes the result.

Behaviour:
- Reset: asynchronous, active-high.
  - Clears: state=IDLE, s1_valid=0, acc=0, cnt=0, ovf=0, acc_out=0, acc_cnt=0, acc_ovf=0, acc_valid=0.
  - `prod_ready` is forced to 0 while rst=1.
  - Reset mid-group discards every partial sum and any held result.
- Stage 1, input register:
  - Accept when prod_valid & prod_ready.
  - On accept, capture `prod` and `prod_last` into s1 and set s1_valid=1.
- Stage 2, accumulate:
  - s1 advances when s1_valid & !(s1_last & acc_valid & !acc_ready).
  - `prod_ready` = !rst & !clr & (!s1_valid | advance).
  - This sustains one product per cycle when not stalled.
- Arithmetic on advance:
  - sum = acc + zero_ext(s1_prod), computed in ACC_W+1 bits.
  - acc takes sum[ACC_W-1:0].
  - ovf_next = ovf | sum[ACC_W].
  - cnt_next = cnt+1, saturating at 2^CNT_W−1.
- Group end: on advance with s1_last=1:
  - acc_out=sum[ACC_W-1:0], acc_cnt=cnt_next, acc_ovf=ovf_next, acc_valid=1.
  - acc, cnt and ovf clear to 0 in the same edge; state returns to IDLE.
- FSM, two states:
  - IDLE: no terms in the current group. Advance with !s1_last → ACCUM. Advance with s1_last → IDLE.
  - ACCUM: ≥1 term held. Advance with s1_last → IDLE. clr → IDLE.
- Latency:
  - Product accepted at edge k is summed at edge k+1.
  - For a last product, acc_valid=1 is visible after edge k+1.
- Output handshake:
  - acc_valid clears on acc_valid & acc_ready, unless a new result loads on the same edge; then acc_valid stays 1 and the fields take the new values.
  - Output fields hold stable while acc_valid & !acc_ready.
- clr: synchronous, highest priority among non-reset events.
  - Clears s1_valid, acc, cnt and ovf; state → IDLE.
  - Does not touch acc_out, acc_cnt, acc_ovf or acc_valid; an already-held result survives.
  - A product presented in the clr cycle is not accepted.
- Single-term group (prod_last on the first term): acc_out=prod, acc_cnt=1.
- Stall: a non-last s1 term still advances while the output is blocked. Only a last term stalls.

Decomposition:
- Shared package:
  - ACC_W and CNT_W defaults.
  - The state enum (IDLE, ACCUM).
  - The 8-bit product width constant, matching the 4x4 multiplier output.
- No sub-module is required. The accumulator adder is a behavioural ACC_W+1-bit add.
- Multiplier-plus-accumulator integration is done in a separate top wrapper, not here.

Test Plan:
- Reset: rst pulse mid-group after products 100 and 50, then group {7 last} → acc_out=7, acc_cnt=1, acc_ovf=0; pre-reset sum never appears.
- Basic group: products 6, 225, 12 (last) back to back, acc_ready=1 → one result: acc_out=243, acc_cnt=3, acc_ovf=0, acc_valid high exactly 1 cycle; prod_ready constantly 1.
- Overflow and saturation: 292 products of 225, last on the 292nd → acc_out=164, acc_ovf=1, acc_cnt=255; next group {1 last} → acc_out=1, acc_ovf=0, acc_cnt=1.
- Backpressure:
  - Stimulus: groups {10 last} then {20, 30 last} back to back, with acc_ready=0 for 10 cycles.
  - Required: the 10/1 result is held stable; 20 is still accumulated; prod_ready drops with 30 in s1.
  - Required: when acc_ready rises, the results 10/1 then 50/2 appear in order with no loss.
- clr mid-group:
  - Stimulus: products 40 and 60, clr for one cycle with prod_valid=1 (the product is not accepted), then {5 last}.
  - Required: acc_out=5, acc_cnt=1.
  - Required: a result held across the clr cycle is unchanged.
- Zero and same-edge replace: group {0 last} → acc_out=0, acc_cnt=1. With acc_ready=1 and a new last advancing on the same edge, acc_valid stays 1 and the fields update.
